arps_axil_ctrl: RTL and testbench
=================================

Name: arps_axil_ctrl

Overview:
Parametrised AXI4-Lite slave control/status block for the ARPS motion-estimation core. It replaces a fixed 4-bit-address register window with a configurable bank of user registers, byte-strobe writes and a start/busy/done handshake to the core. It also provides a maskable, sticky done interrupt. It sits between the PS AXI-Lite master and the core's control inputs (start, frame parameters) and drives interrupt_o.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; must be 32 or 64.
C_S_AXI_ADDR_WIDTH, 6, byte-address width; must be >= clog2(NUM_USER_REGS+2) + clog2(C_S_AXI_DATA_WIDTH/8).
NUM_USER_REGS, 4, number of RW user registers exported to the core (1..16).

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
s_axi_awaddr/awprot/awvalid  in  ADDR_W/3/1  write address channel (awprot ignored)
s_axi_awready  out  1  write address ready
s_axi_wdata/wstrb/wvalid  in  DATA_W/DATA_W/8/1  write data channel
s_axi_wready  out  1  write data ready
s_axi_bresp/bvalid  out  2/1  write response; s_axi_bready in 1
s_axi_araddr/arprot/arvalid  in  ADDR_W/3/1  read address channel (arprot ignored)
s_axi_arready  out  1  read address ready
s_axi_rdata/rresp/rvalid  out  DATA_W/2/1  read data channel; s_axi_rready in 1
start_o  out  1  one-cycle start pulse to the core
done_i  in  1  one-cycle completion pulse from the core
user_regs_o  out  NUM_USER_REGS*DATA_W  flattened user registers; reg i in bits [i*DATA_W +: DATA_W]
interrupt_o  out  1  level interrupt, registered

Behaviour:
- Register map (word index = addr >> clog2(DATA_W/8)): 0 CTRL (bit0 START, W1 self-clearing, reads 0; bit1 IRQ_EN, RW). 1 STATUS (bit0 BUSY, RO; bit1 DONE, sticky, W1C). 2..NUM_USER_REGS+1 USER[i], RW. Unused bits read 0.
- Reset: all ready/valid outputs 0, rdata 0, bresp/rresp 0, start_o 0, interrupt_o 0, IRQ_EN/BUSY/DONE 0, all USER regs 0. Reset asserted mid-transaction drops the transaction; no response is issued afterwards.
- Write path: AW and W latch independently. awready=1 while no address is held and bvalid=0; wready=1 while no data is held and bvalid=0. They may complete in the same cycle or in either order.
- Write commit: in the cycle both AW and W are held, the register updates on the next edge. bvalid rises on that same edge and is held until bready; new AW/W are accepted only after the B handshake.
- Byte strobes: wstrb applies per byte to USER and to CTRL.IRQ_EN. START and DONE-W1C act only when wstrb[0]=1.
- Read path: arready=1 while rvalid=0. An AR handshake at edge n gives rdata/rvalid valid after edge n+1. rdata is stable until the rready handshake.
- Out-of-range word index (> NUM_USER_REGS+1): write is discarded with bresp=2'b10. Read returns 0 with rresp=2'b10. In-range accesses return 2'b00.
- Start: a write of START=1 with BUSY=0 sets BUSY and pulses start_o high for exactly one cycle, starting on the edge after the commit. START=1 with BUSY=1 is ignored: no pulse, bresp OKAY.
- Done: done_i while BUSY clears BUSY and sets DONE. done_i while not BUSY is ignored. done_i and a DONE-W1C in the same cycle leave DONE=1 (set wins).
- interrupt_o is registered: it equals DONE & IRQ_EN of the previous cycle. Clearing IRQ_EN or DONE drops it one cycle later.
- A read and a write in flight at the same time are independent. A STATUS read in the commit cycle of a start write returns the pre-write value.

Test Plan:
- Reset check: apply rst mid-write, then release -> all outputs 0, bvalid never asserts for the dropped write, and every register reads 0.
- Write ordering and strobes: W before AW, AW before W, and both in the same cycle, to USER[2] with 0xA5A5A5A5 and wstrb=4'b0101 over prior 0xFFFFFFFF -> reads 0xFFA5FFA5. For each, bvalid 1 cycle after the commit and held through 3 cycles of bready=0.
- Start/done flow: write CTRL=0x3 -> start_o high for exactly 1 cycle and STATUS=0x1. A second START while busy gives no pulse. Pulse done_i -> STATUS=0x2 and interrupt_o=1 one cycle later.
- W1C race: write STATUS=0x2 in the same cycle as a done_i pulse while busy -> DONE stays 1. A later W1C alone -> STATUS=0x0 and interrupt_o=0 one cycle later.
- Out-of-range access with NUM_USER_REGS=4: write 0x12345678 to word 6 -> bresp=2'b10 and no register changes. Read word 6 -> rdata=0 and rresp=2'b10.
- Back-pressure: issue a read with rready=0 for 5 cycles while a write is in flight -> rdata is stable, arready=0 until the handshake, and the write completes independently.

Source files
------------

// File: rtl/arps_axil_ctrl.sv
// AXI4-Lite control/status slave for the ARPS motion-estimation core.
// Provides CTRL (start, irq enable), STATUS (busy, sticky done) and a bank
// of RW user registers, plus a registered, maskable done interrupt.
module arps_axil_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_USER_REGS      = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             s_axi_awaddr,
    input  logic [2:0]                                s_axi_awprot,
    input  logic                                      s_axi_awvalid,
    output logic                                      s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           s_axi_wstrb,
    input  logic                                      s_axi_wvalid,
    output logic                                      s_axi_wready,
    output logic [1:0]                                s_axi_bresp,
    output logic                                      s_axi_bvalid,
    input  logic                                      s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             s_axi_araddr,
    input  logic [2:0]                                s_axi_arprot,
    input  logic                                      s_axi_arvalid,
    output logic                                      s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             s_axi_rdata,
    output logic [1:0]                                s_axi_rresp,
    output logic                                      s_axi_rvalid,
    input  logic                                      s_axi_rready,
    output logic                                      start_o,
    input  logic                                      done_i,
    output logic [NUM_USER_REGS*C_S_AXI_DATA_WIDTH-1:0] user_regs_o,
    output logic                                      interrupt_o
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int LAST_IDX = NUM_USER_REGS + 1;

    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      wr_idx;
    logic [DW-1:0]         w_data_q;
    logic [NB-1:0]         w_strb_q;
    logic                  ar_pend;
    logic [IDX_W-1:0]      rd_idx;
    logic [DW-1:0]         rd_val;
    logic                  rd_oor;
    logic [DW-1:0]         user_q [NUM_USER_REGS];
    logic                  irq_en, busy, done;

    logic wr_commit, wr_oor, wr_ctrl, wr_stat, start_go, w1c, done_hit;

    // Sideband and sub-word address bits carry no information for this block
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s_axi_awprot, s_axi_arprot,
                             s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    // Ready flags are held low in reset so nothing is accepted then
    assign s_axi_awready = ~rst & ~aw_held & ~s_axi_bvalid;
    assign s_axi_wready  = ~rst & ~w_held  & ~s_axi_bvalid;
    assign s_axi_arready = ~rst & ~ar_pend & ~s_axi_rvalid;

    assign wr_commit = aw_held & w_held;
    assign wr_oor    = 32'(wr_idx) > 32'(LAST_IDX);
    assign wr_ctrl   = wr_commit && (32'(wr_idx) == 32'd0);
    assign wr_stat   = wr_commit && (32'(wr_idx) == 32'd1);
    assign start_go  = wr_ctrl & w_strb_q[0] & w_data_q[0] & ~busy;
    assign w1c       = wr_stat & w_strb_q[0] & w_data_q[1];
    assign done_hit  = done_i & busy;

    // Write channel: latch AW and W independently, commit once both are held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            wr_idx       <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                wr_idx  <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (wr_commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_oor ? 2'b10 : 2'b00;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    // Control/status state; a done pulse and a W1C in the same cycle keep DONE set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_o     <= 1'b0;
            interrupt_o <= 1'b0;
        end else begin
            if (wr_ctrl && w_strb_q[0])
                irq_en <= w_data_q[1];
            if (done_hit)
                busy <= 1'b0;
            else if (start_go)
                busy <= 1'b1;
            done        <= done_hit | (done & ~w1c);
            start_o     <= start_go;
            interrupt_o <= done & irq_en;
        end
    end

    // User registers with per-byte strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_USER_REGS; i++)
                user_q[i] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NUM_USER_REGS; i++)
                for (int b = 0; b < NB; b++)
                    if ((32'(wr_idx) == 32'(i + 2)) && w_strb_q[b])
                        user_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
        end
    end

    // Read mux; out-of-range indices fall through to zero
    always_comb begin
        rd_val = '0;
        rd_oor = 32'(rd_idx) > 32'(LAST_IDX);
        if (32'(rd_idx) == 32'd0)
            rd_val[1] = irq_en;
        if (32'(rd_idx) == 32'd1)
            rd_val[1:0] = {done, busy};
        for (int i = 0; i < NUM_USER_REGS; i++)
            if (32'(rd_idx) == 32'(i + 2))
                rd_val = user_q[i];
    end

    // Read channel: one pending cycle between AR handshake and rvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_pend      <= 1'b0;
            rd_idx       <= '0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                ar_pend <= 1'b1;
                rd_idx  <= s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            end
            if (ar_pend) begin
                ar_pend      <= 1'b0;
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
                s_axi_rresp  <= rd_oor ? 2'b10 : 2'b00;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_USER_REGS; g++) begin : g_user_out
        assign user_regs_o[g*DW +: DW] = user_q[g];
    end
endmodule

// File: tb/tb_arps_axil_ctrl.sv
// Directed bench for arps_axil_ctrl with hand-computed expectations.
module tb_arps_axil_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   s_axi_awaddr = '0;
    logic [2:0]   s_axi_awprot = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [5:0]   s_axi_araddr = '0;
    logic [2:0]   s_axi_arprot = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic         start_o;
    logic         done_i = 1'b0;
    logic [127:0] user_regs_o;
    logic         interrupt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    arps_axil_ctrl #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .NUM_USER_REGS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .start_o(start_o), .done_i(done_i),
        .user_regs_o(user_regs_o), .interrupt_o(interrupt_o)
    );

    always #5 clk = ~clk;

    // Counts cycles in which start_o is high
    always @(posedge clk) if (start_o) start_cnt <= start_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: AW and W together, 1: AW first, 2: W first
    task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int hold, input bit done_pulse,
                          output logic [1:0] resp, output logic irq0, output logic irq1);
        s_axi_bready = 1'b0;
        if (mode == 0) begin
            s_axi_awaddr = a; s_axi_awvalid = 1'b1;
            s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
            tick();
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        end else if (mode == 1) begin
            s_axi_awaddr = a; s_axi_awvalid = 1'b1;
            tick();
            s_axi_awvalid = 1'b0;
            s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
            tick();
            s_axi_wvalid = 1'b0;
        end else begin
            s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
            tick();
            s_axi_wvalid = 1'b0;
            s_axi_awaddr = a; s_axi_awvalid = 1'b1;
            tick();
            s_axi_awvalid = 1'b0;
        end
        check_eq("bvalid_commit_cycle", s_axi_bvalid, 1'b0);
        if (done_pulse) done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check_eq("bvalid_rise", s_axi_bvalid, 1'b1);
        resp = s_axi_bresp;
        irq0 = interrupt_o;
        irq1 = interrupt_o;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (i == 0) irq1 = interrupt_o;
            check_eq("bvalid_hold", s_axi_bvalid, 1'b1);
        end
        s_axi_bready = 1'b1;
        tick();
        if (hold == 0) irq1 = interrupt_o;
        s_axi_bready = 1'b0;
        check_eq("bvalid_fall", s_axi_bvalid, 1'b0);
    endtask

    task automatic axi_rd(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check_eq("rvalid_latency", s_axi_rvalid, 1'b0);
        tick();
        check_eq("rvalid_rise", s_axi_rvalid, 1'b1);
        d = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    logic [31:0]  rd_d, d0;
    logic [1:0]   rsp;
    logic         i0, i1;
    logic [127:0] u_snap;
    int           s0;
    logic [5:0]   map_addr;
    logic [1:0]   wmode;

    initial begin
        // Reset state
        repeat (3) tick();
        check_eq("rst_awready", s_axi_awready, 1'b0);
        check_eq("rst_wready", s_axi_wready, 1'b0);
        check_eq("rst_arready", s_axi_arready, 1'b0);
        check_eq("rst_bvalid", s_axi_bvalid, 1'b0);
        check_eq("rst_rvalid", s_axi_rvalid, 1'b0);
        check_eq("rst_rdata", s_axi_rdata, 32'h0);
        check_eq("rst_start", start_o, 1'b0);
        check_eq("rst_irq", interrupt_o, 1'b0);
        check_eq("rst_user", user_regs_o, 128'h0);
        rst = 1'b0;
        tick();

        // Reset asserted between handshake and commit drops the write
        s_axi_awaddr = 6'h0C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("dropped_bvalid", s_axi_bvalid, 1'b0);
        end
        check_eq("post_rst_awready", s_axi_awready, 1'b1);
        check_eq("post_rst_user", user_regs_o, 128'h0);
        for (int w = 0; w < 6; w++) begin
            map_addr = 6'(w * 4);
            axi_rd(map_addr, rd_d, rsp);
            check_eq("post_rst_read", rd_d, 32'h0);
            check_eq("post_rst_rresp", rsp, 2'b00);
        end

        // Byte strobes under all three AW/W orderings
        for (int m = 0; m < 3; m++) begin
            wmode = 2'(m);
            axi_wr(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0, rsp, i0, i1);
            axi_wr(6'h10, 32'hA5A5A5A5, 4'b0101, (wmode == 2'd0) ? 2 : (wmode == 2'd1) ? 1 : 0,
                   3, 1'b0, rsp, i0, i1);
            check_eq("strobe_bresp", rsp, 2'b00);
            axi_rd(6'h10, rd_d, rsp);
            check_eq("strobe_read", rd_d, 32'hFFA5FFA5);
            check_eq("strobe_user_out", user_regs_o[95:64], 32'hFFA5FFA5);
        end

        // Start / done flow
        s0 = start_cnt;
        axi_wr(6'h00, 32'h3, 4'hF, 0, 1, 1'b0, rsp, i0, i1);
        check_eq("start_pulse_count", 32'(start_cnt - s0), 32'd1);
        check_eq("start_low_after", start_o, 1'b0);
        axi_rd(6'h04, rd_d, rsp);
        check_eq("status_busy", rd_d, 32'h1);
        axi_rd(6'h00, rd_d, rsp);
        check_eq("ctrl_read", rd_d, 32'h2);
        s0 = start_cnt;
        axi_wr(6'h00, 32'h3, 4'hF, 0, 1, 1'b0, rsp, i0, i1);
        check_eq("start_busy_no_pulse", 32'(start_cnt - s0), 32'd0);
        check_eq("start_busy_bresp", rsp, 2'b00);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check_eq("irq_not_yet", interrupt_o, 1'b0);
        tick();
        check_eq("irq_set", interrupt_o, 1'b1);
        axi_rd(6'h04, rd_d, rsp);
        check_eq("status_done", rd_d, 32'h2);

        // W1C racing a done pulse keeps DONE set
        s0 = start_cnt;
        axi_wr(6'h00, 32'h3, 4'hF, 0, 1, 1'b0, rsp, i0, i1);
        check_eq("restart_pulse", 32'(start_cnt - s0), 32'd1);
        axi_rd(6'h04, rd_d, rsp);
        check_eq("status_busy_done", rd_d, 32'h3);
        axi_wr(6'h04, 32'h2, 4'hF, 0, 1, 1'b1, rsp, i0, i1);
        axi_rd(6'h04, rd_d, rsp);
        check_eq("w1c_race_status", rd_d, 32'h2);
        check_eq("w1c_race_irq", interrupt_o, 1'b1);
        axi_wr(6'h04, 32'h2, 4'hF, 0, 2, 1'b0, rsp, i0, i1);
        check_eq("w1c_irq_commit_edge", i0, 1'b1);
        check_eq("w1c_irq_next", i1, 1'b0);
        axi_rd(6'h04, rd_d, rsp);
        check_eq("w1c_status", rd_d, 32'h0);

        // Out-of-range word index
        u_snap = user_regs_o;
        axi_wr(6'h18, 32'h12345678, 4'hF, 0, 0, 1'b0, rsp, i0, i1);
        check_eq("oor_bresp", rsp, 2'b10);
        check_eq("oor_user_unchanged", user_regs_o, u_snap);
        axi_rd(6'h18, rd_d, rsp);
        check_eq("oor_rdata", rd_d, 32'h0);
        check_eq("oor_rresp", rsp, 2'b10);
        axi_rd(6'h00, rd_d, rsp);
        check_eq("oor_ctrl_unchanged", rd_d, 32'h2);

        // Read back-pressure with an independent write in flight
        s_axi_araddr = 6'h10; s_axi_arvalid = 1'b1;
        s_axi_awaddr = 6'h08; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        check_eq("bp_arready_idle", s_axi_arready, 1'b1);
        tick();
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check_eq("bp_arready_pend", s_axi_arready, 1'b0);
        tick();
        check_eq("bp_rvalid", s_axi_rvalid, 1'b1);
        check_eq("bp_bvalid", s_axi_bvalid, 1'b1);
        check_eq("bp_rdata", s_axi_rdata, 32'hFFA5FFA5);
        d0 = s_axi_rdata;
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check_eq("bp_write_done", s_axi_bvalid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_rdata_stable", s_axi_rdata, d0);
            check_eq("bp_rvalid_held", s_axi_rvalid, 1'b1);
            check_eq("bp_arready_low", s_axi_arready, 1'b0);
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check_eq("bp_rvalid_fall", s_axi_rvalid, 1'b0);
        check_eq("bp_arready_back", s_axi_arready, 1'b1);
        check_eq("bp_user0_out", user_regs_o[31:0], 32'h11223344);
        axi_rd(6'h08, rd_d, rsp);
        check_eq("bp_user0_read", rd_d, 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
